seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Shares one BCD-to-segment decoder between all digits.
- Accepts a packed BCD word through a valid/ready handshake and applies it atomically at frame boundaries.
- Provides dead-time blanking between digits, leading-zero blanking and per-digit decimal points. Sits between the counter/datapath logic and the display pins.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_decoder.sv | 16 +
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: segment codes, field widths
// and the scan state encoding.
package seg_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    // Segment order {a,b,c,d,e,f,g}, a in the MSB; a 0 lights the segment.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_TABLE [0:9] = '{
        7'b0000001,
        7'b1001111,
        7'b0010010,
        7'b0000110,
        7'b1001100,
        7'b0100100,
        7'b0100000,
        7'b0001111,
        7'b0000000,
        7'b0000100
    };

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes render blank.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with frame-atomic
// BCD updates, dead-time blanking, leading-zero blanking and decimal points.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [BCD_W*N_DIGITS-1:0] i_bcd,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_lzb_en,
    input  logic [N_DIGITS-1:0]       i_dp,
    output logic [SEG_W-1:0]          o_segments,
    output logic                      o_dp,
    output logic [N_DIGITS-1:0]       o_digit_en_n,
    output logic                      o_frame_done,
    output scan_state_e               o_dbg_state
);

    localparam int CW    = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int WORD_W = BCD_W * N_DIGITS;

    localparam logic [CW-1:0]    CNT_LAST      = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]    CNT_PRE_LAST  = CW'(PRESCALE - 2);
    localparam logic [CW-1:0]    CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = BLANK;
    localparam logic [0:0] ST_SHOW  = SHOW;

    if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_digits
        $error("seg_scan_ctrl: N_DIGITS must be in 2..8");
    end
    if (PRESCALE < 4) begin : g_bad_prescale
        $error("seg_scan_ctrl: PRESCALE must be at least 4");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
        $error("seg_scan_ctrl: BLANK_CYCLES must be in 1..PRESCALE-1");
    end

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [IDX_W-1:0] idx;
    logic [WORD_W-1:0] active;
    logic [WORD_W-1:0] pending;
    logic             pending_full;

    logic             slot_end;
    logic             frame_end;
    logic             xfer;
    logic [BCD_W-1:0] cur_nibble;
    logic             upper_zero;
    logic             lz_hit;
    logic [SEG_W-1:0] dec_seg;
    logic [SEG_W-1:0] seg_next;

    // Valid/ready: a word transfers on any clock edge where i_valid and o_ready
    // are both high; o_ready depends only on registered state, never on i_valid.
    assign o_ready     = ~pending_full;
    assign xfer        = i_valid && o_ready;
    assign slot_end    = (cnt == CNT_LAST);
    assign frame_end   = slot_end && (idx == IDX_LAST);
    assign o_dbg_state = scan_state_e'(state);

    always_comb begin
        cur_nibble = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nibble = active[k*BCD_W +: BCD_W];
            end
        end
    end

    // Walk down from the top digit: a digit is a leading zero while every
    // nibble from it upward is zero. Digit 0 is never considered.
    always_comb begin
        upper_zero = 1'b1;
        lz_hit     = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (active[k*BCD_W +: BCD_W] == '0);
            if (idx == IDX_W'(k) && upper_zero) begin
                lz_hit = 1'b1;
            end
        end
    end

    seg_decoder u_dec (
        .bcd (cur_nibble),
        .seg (dec_seg)
    );

    assign seg_next = (i_lzb_en && lz_hit) ? SEG_BLANK : dec_seg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_BLANK;
            cnt          <= '0;
            idx          <= '0;
            o_segments   <= SEG_BLANK;
            o_dp         <= 1'b1;
            o_digit_en_n <= '1;
            o_frame_done <= 1'b0;
        end else begin
            cnt          <= slot_end ? '0 : cnt + 1'b1;
            o_frame_done <= (cnt == CNT_PRE_LAST) && (idx == IDX_LAST);
            case (state)
                ST_BLANK: begin
                    o_segments <= seg_next;
                    o_dp       <= ~i_dp[idx];
                    if (cnt == CNT_BLANK_END) begin
                        state        <= ST_SHOW;
                        o_digit_en_n <= ~(N_DIGITS'(1) << idx);
                    end
                end
                ST_SHOW: begin
                    if (slot_end) begin
                        state        <= ST_BLANK;
                        o_digit_en_n <= '1;
                        o_segments   <= SEG_BLANK;
                        o_dp         <= 1'b1;
                        idx          <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

    // The displayed word only moves at the frame boundary; a word arriving on
    // the boundary cycle itself bypasses the pending buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (frame_end) begin
            if (pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end else if (xfer) begin
                active <= i_bcd;
            end
        end else if (xfer) begin
            pending      <= i_bcd;
            pending_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus randomized bench for seg_scan_ctrl against a cycle-counting
// reference model derived from the display rules.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;
    localparam int W = 4 * N;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] bcd    = '0;
    logic         valid  = 1'b0;
    logic         lzb_en = 1'b0;
    logic [N-1:0] dp_in  = '0;
    logic         ready;
    logic [6:0]   segments;
    logic         dp_out;
    logic [N-1:0] en_n;
    logic         frame_done;
    scan_state_e  dbg_state;

    seg_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_bcd        (bcd),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_lzb_en     (lzb_en),
        .i_dp         (dp_in),
        .o_segments   (segments),
        .o_dp         (dp_out),
        .o_digit_en_n (en_n),
        .o_frame_done (frame_done),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- reference model ----------------
    int           n_vec = 0;
    int           n_err = 0;
    int           t;
    logic [W-1:0] m_active;
    logic [W-1:0] exp_q[$];
    logic [6:0]   seg_lat;
    logic         dp_lat;

    function automatic logic [6:0] ref_seg(input logic [W-1:0] word, input int k, input logic lzb);
        logic [W-1:0] upper;
        logic [3:0]   d;
        upper = word >> (4 * k);
        d     = upper[3:0];
        if (lzb && k > 0 && upper == '0) return 7'h7F;
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic model_reset();
        t        = 0;
        m_active = '0;
        exp_q.delete();
        seg_lat  = 7'h7F;
        dp_lat   = 1'b1;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        int pos, slot;
        pos  = t % P;
        slot = (t / P) % N;
        if (pos == B - 1) begin
            seg_lat = ref_seg(m_active, slot, lzb_en);
            dp_lat  = ~dp_in[slot];
        end
        if (pos == P - 1 && slot == N - 1) begin
            if (exp_q.size() > 0) m_active = exp_q.pop_front();
            else if (valid)       m_active = bcd;
        end else if (valid && exp_q.size() == 0) begin
            exp_q.push_back(bcd);
        end
        t++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int pos, slot;
        logic [N-1:0] exp_en;
        pos    = t % P;
        slot   = (t / P) % N;
        exp_en = (pos >= B) ? ~(N'(1) << slot) : '1;
        check("digit_en_n", 32'(en_n), 32'(exp_en));
        check("frame_done", 32'(frame_done), 32'(pos == P - 1 && slot == N - 1));
        check("ready", 32'(ready), 32'(exp_q.size() == 0));
        if (pos >= B) begin
            check("segments", 32'(segments), 32'(seg_lat));
            check("dp", 32'(dp_out), 32'(dp_lat));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [W-1:0] word);
        int w;
        bcd   = word;
        valid = 1'b1;
        w     = 0;
        while (!ready && w < 200) begin
            step();
            w++;
        end
        check("send_ready_before_timeout", 32'(ready), 32'd1);
        step();
        valid = 1'b0;
        bcd   = W'($urandom);
    endtask

    task automatic wait_until(input int pos, input int slot);
        int w;
        w = 0;
        while (!((t % P) == pos && ((t / P) % N) == slot) && w < 200) begin
            step();
            w++;
        end
        check("wait_position_reached", 32'(t % P), 32'(pos));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_cycle();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_en_n", 32'(en_n), 32'hF);
        check("reset_segments", 32'(segments), 32'h7F);
        check("reset_dp", 32'(dp_out), 32'd1);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        release_reset();

        // First word offered in cycle 5, shown from the second frame.
        run(5);
        send(16'h1234);
        run(2 * N * P);

        lzb_en = 1'b1;
        send(16'h0050);
        run(2 * N * P);
        lzb_en = 1'b0;
        run(N * P);

        dp_in = 4'b0010;
        send(16'h00A7);
        run(2 * N * P);
        dp_in = '0;

        send(16'h1111);
        send(16'h2222);
        run(3 * N * P);

        // Word arriving exactly on the boundary cycle with nothing pending.
        wait_until(P - 1, N - 1);
        send(16'h9876);
        run(2 * N * P);

        for (int i = 0; i < 25; i++) begin
            lzb_en = 1'($urandom_range(0, 1));
            dp_in  = N'($urandom);
            if ($urandom_range(0, 3) == 0) send(16'h0000 | W'($urandom_range(0, 255)));
            else                           send(W'($urandom));
            run($urandom_range(0, 40));
        end
        run(N * P);

        // Asynchronous reset in the middle of digit 2's lit window.
        lzb_en = 1'b0;
        dp_in  = '0;
        send(16'h5678);
        run(N * P);
        wait_until(B + 2, 2);
        rst_n = 1'b0;
        #1;
        check("midreset_en_n", 32'(en_n), 32'hF);
        check("midreset_segments", 32'(segments), 32'h7F);
        check("midreset_dp", 32'(dp_out), 32'd1);
        check("midreset_ready", 32'(ready), 32'd1);
        #20;
        release_reset();
        run(2 * N * P);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
